// File: rtl/canvas_pkg.sv
// Shared constants for the 8x8 canvas: geometry, command opcodes and readout modes.
package canvas_pkg;

    localparam int unsigned CANVAS_W = 8;
    localparam int unsigned CANVAS_H = 8;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_UP     = 4'd1,
        OP_DOWN   = 4'd2,
        OP_LEFT   = 4'd3,
        OP_RIGHT  = 4'd4,
        OP_SET    = 4'd5,
        OP_CLR    = 4'd6,
        OP_TOGGLE = 4'd7,
        OP_CLEAR  = 4'd8,
        OP_FILL   = 4'd9,
        OP_HOME   = 4'd10
    } opcode_t;

    typedef enum logic {
        RD_ROW    = 1'b0,
        RD_STATUS = 1'b1
    } rd_mode_t;

endpackage

// File: rtl/canvas_cmd_sync.sv
// Two-flop synchronizer for ui_in plus rising-edge detect on the command strobe.
module canvas_cmd_sync
    import canvas_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic       fire,
    output logic [4:0] cmd
);

    logic [7:0] s1;
    logic [7:0] s2;
    logic       prev;
    logic [1:0] unused_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            prev <= 1'b0;
        end else begin
            s1   <= ui_in;
            s2   <= s1;
            prev <= s2[7];
        end
    end

    // prev tracks s2[7] regardless of ena, so edges seen while disabled are consumed.
    assign fire        = s2[7] & ~prev;
    assign cmd         = s2[4:0];
    assign unused_bits = s2[6:5];

endmodule

// File: rtl/tt_um_canvas.sv
// 8x8 monochrome canvas: strobed commands move a cursor and draw; rows/status read back on uo_out.
module tt_um_canvas
    import canvas_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // rst_n is active-high on this tile.
    logic       rst;
    logic       fire;
    logic [4:0] cmd;
    logic [7:0] pix [CANVAS_H];
    logic [2:0] x;
    logic [2:0] y;
    logic       pen;
    logic [2:0] nx;
    logic [2:0] ny;
    logic       is_move;
    opcode_t    op;
    rd_mode_t   mode;
    logic [3:0] unused_uio;

    assign rst = rst_n;

    canvas_cmd_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .ui_in (ui_in),
        .fire  (fire),
        .cmd   (cmd)
    );

    assign op = opcode_t'(cmd[3:0]);

    always_comb begin
        nx      = x;
        ny      = y;
        is_move = 1'b0;
        case (op)
            OP_UP:    begin ny = y - 3'd1; is_move = 1'b1; end
            OP_DOWN:  begin ny = y + 3'd1; is_move = 1'b1; end
            OP_LEFT:  begin nx = x - 3'd1; is_move = 1'b1; end
            OP_RIGHT: begin nx = x + 3'd1; is_move = 1'b1; end
            OP_HOME:  begin nx = '0; ny = '0; is_move = 1'b1; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < CANVAS_H; r++) pix[r] <= '0;
            x   <= '0;
            y   <= '0;
            pen <= 1'b0;
        end else if (fire && ena) begin
            pen <= cmd[4];
            x   <= nx;
            y   <= ny;
            // Pen-down moves mark the pixel at the destination cursor.
            if (is_move && cmd[4]) pix[ny][nx] <= 1'b1;
            case (op)
                OP_SET:    pix[y][x] <= 1'b1;
                OP_CLR:    pix[y][x] <= 1'b0;
                OP_TOGGLE: pix[y][x] <= ~pix[y][x];
                OP_CLEAR:  for (int unsigned r = 0; r < CANVAS_H; r++) pix[r] <= '0;
                OP_FILL:   for (int unsigned r = 0; r < CANVAS_H; r++) pix[r] <= '1;
                default:   ;
            endcase
        end
    end

    assign mode       = rd_mode_t'(uio_in[3]);
    assign uo_out     = (mode == RD_STATUS) ? {pen, pix[y][x], y, x} : pix[uio_in[2:0]];
    assign uio_out    = '0;
    assign uio_oe     = '0;
    assign unused_uio = uio_in[7:4];

endmodule

// File: tb/tb_tt_um_canvas.sv
// Directed self-checking bench for tt_um_canvas with hand-computed readout values.
module tb_tt_um_canvas;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_pass   = 0;

    tt_um_canvas dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 8'h%02h expected 8'h%02h", tag, got, exp);
    endtask

    // Strobe high for 4 cycles then low for 4; returns on a negedge.
    task automatic send(input logic [3:0] op, input logic pen);
        ui_in = {1'b1, 2'b00, pen, op};
        repeat (4) @(negedge clk);
        ui_in = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    task automatic read_status(input string tag, input logic [7:0] exp);
        uio_in = 8'h08;
        #1 check(tag, uo_out, exp);
    endtask

    task automatic read_row(input string tag, input logic [2:0] r, input logic [7:0] exp);
        uio_in = {5'b00000, r};
        #1 check(tag, uo_out, exp);
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);

        // Reset state
        read_status("rst_status", 8'h00);
        for (int r = 0; r < 8; r++) read_row($sformatf("rst_row%0d", r), r[2:0], 8'h00);
        check("uio_oe", uio_oe, 8'h00);
        check("uio_out", uio_out, 8'h00);

        // SET at origin
        send(4'd5, 1'b0);
        read_row("set_row0", 3'd0, 8'h01);
        read_status("set_status", 8'h40);

        // Wrap-around moves
        send(4'd3, 1'b0);
        send(4'd1, 1'b0);
        read_status("wrap_xy7", 8'h3F);
        send(4'd4, 1'b0);
        read_status("wrap_x0", 8'h38);

        // Pen-down drawing
        send(4'd8, 1'b0);
        send(4'd10, 1'b0);
        read_status("home", 8'h00);
        repeat (3) send(4'd4, 1'b1);
        read_row("pen_row0", 3'd0, 8'h0E);
        read_status("pen_status", 8'hC3);

        // FILL, then CLR at (2,5)
        send(4'd9, 1'b0);
        send(4'd10, 1'b0);
        repeat (2) send(4'd4, 1'b0);
        repeat (5) send(4'd2, 1'b0);
        send(4'd6, 1'b0);
        read_status("clr_status", 8'h2A);
        for (int r = 0; r < 8; r++)
            read_row($sformatf("fill_row%0d", r), r[2:0], (r == 5) ? 8'hFB : 8'hFF);
        send(4'd8, 1'b0);
        for (int r = 0; r < 8; r++) read_row($sformatf("clear_row%0d", r), r[2:0], 8'h00);

        // Held strobe fires once
        ui_in = 8'h84;
        repeat (10) @(negedge clk);
        ui_in = 8'h00;
        repeat (4) @(negedge clk);
        read_status("held_once", 8'h2B);

        // Disabled: edge consumed, not queued
        ena = 1'b0;
        send(4'd4, 1'b0);
        ena = 1'b1;
        repeat (4) @(negedge clk);
        read_status("ena_off", 8'h2B);

        // Toggle twice at (3,5)
        send(4'd7, 1'b0);
        read_row("toggle_on", 3'd5, 8'h08);
        send(4'd7, 1'b0);
        read_row("toggle_off", 3'd5, 8'h00);

        // Strobe held through reset fires once after release
        ui_in = 8'h84;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        read_status("mid_rst", 8'h00);
        rst_n = 1'b0;
        repeat (6) @(negedge clk);
        read_status("post_rst_fire", 8'h01);
        ui_in = 8'h00;
        repeat (4) @(negedge clk);
        read_status("post_rst_once", 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
